// File: rtl/ttt_uart_pkg.sv
// ttt_uart_pkg
// Shared definitions for the tic-tac-toe UART console: ASCII constants,
// receive byte classification and the move parser state encoding. The result
// printer uses the same ASCII constants for its message bytes.
package ttt_uart_pkg;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_R_LO = 8'h72;
    localparam logic [7:0] CH_R_UP = 8'h52;

    typedef enum logic [2:0] {
        BC_DIGIT,
        BC_TERM,
        BC_SPACE,
        BC_RST,
        BC_OTHER
    } byte_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGIT,
        S_OUT,
        S_DISCARD
    } rm_state_e;

    // '0' is deliberately not a digit: cells are numbered 1..9 on the console.
    function automatic byte_class_e classify(input logic [7:0] b);
        if (b >= CH_1 && b <= CH_9)
            return BC_DIGIT;
        else if (b == CH_CR || b == CH_LF)
            return BC_TERM;
        else if (b == CH_SP)
            return BC_SPACE;
        else if (b == CH_R_LO || b == CH_R_UP)
            return BC_RST;
        else
            return BC_OTHER;
    endfunction

    // Low nibble of '1'..'9' is 1..9, so the cell index is that nibble minus 1.
    function automatic logic [3:0] digit_index(input logic [3:0] lo_nibble);
        return lo_nibble - 4'd1;
    endfunction

endpackage

// File: rtl/read_move.sv
// read_move
// Receive-side command parser for the tic-tac-toe UART console. Decodes a
// move ('1'..'9' then CR/LF) into a cell index 0..8 offered with valid/ack,
// decodes the restart command ('r'/'R') and pulses err on malformed input,
// bytes dropped while a move is pending, or a digit left unterminated.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   uart_rd    in   one-cycle strobe, uart_d valid this cycle
//   uart_d     in   received byte
//   move_valid out  decoded move available, held until move_ack
//   move_pos   out  cell index 0..8, stable while move_valid
//   move_ack   in   consumer accepts the move when move_valid=1
//   restart    out  one-cycle pulse on restart command
//   err        out  one-cycle pulse on malformed input / drop / timeout
module read_move
    import ttt_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rd,
    input  logic [7:0] uart_d,
    output logic       move_valid,
    output logic [3:0] move_pos,
    input  logic       move_ack,
    output logic       restart,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The timer is cleared in the strobe cycle of the digit, so the expiry
    // cycle is the one where it has already counted TIMEOUT_CYCLES-1 idle
    // cycles and would reach TIMEOUT_CYCLES on this edge.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    rm_state_e     r_state;
    logic [3:0]    r_digit;
    logic [TW-1:0] r_timer;
    logic          r_move_valid;
    logic [3:0]    r_move_pos;
    logic          r_restart;
    logic          r_err;

    byte_class_e   w_cls;

    assign w_cls = classify(uart_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_digit      <= '0;
            r_timer      <= '0;
            r_move_valid <= 1'b0;
            r_move_pos   <= '0;
            r_restart    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_restart <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (uart_rd) begin
                        case (w_cls)
                            BC_DIGIT: begin
                                r_digit <= digit_index(uart_d[3:0]);
                                r_timer <= '0;
                                r_state <= S_DIGIT;
                            end
                            BC_RST:   r_restart <= 1'b1;
                            BC_OTHER: begin
                                r_err   <= 1'b1;
                                r_state <= S_DISCARD;
                            end
                            default: ;  // TERM / SPACE ignored
                        endcase
                    end
                end

                S_DIGIT: begin
                    // A byte in the expiry cycle wins over the timeout.
                    if (uart_rd) begin
                        case (w_cls)
                            BC_TERM: begin
                                r_move_valid <= 1'b1;
                                r_move_pos   <= r_digit;
                                r_state      <= S_OUT;
                            end
                            BC_SPACE: ;  // timer neither cleared nor advanced
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= S_DISCARD;
                            end
                        endcase
                    end else if (r_timer >= T_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_DISCARD: begin
                    if (uart_rd && w_cls == BC_TERM)
                        r_state <= S_IDLE;
                end

                S_OUT: begin
                    // Trailing LF of CRLF is absorbed; anything else is dropped.
                    if (uart_rd && w_cls != BC_TERM)
                        r_err <= 1'b1;
                    if (move_ack) begin
                        r_move_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign move_valid = r_move_valid;
    assign move_pos   = r_move_pos;
    assign restart    = r_restart;
    assign err        = r_err;

endmodule

// File: tb/tb_read_move.sv
module tb_read_move;

    localparam int TO = 50;

    logic       clk;
    logic       reset;
    logic       uart_rd;
    logic [7:0] uart_d;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ack;
    logic       restart;
    logic       err;

    int n_chk;
    int n_fail;

    read_move #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rd    (uart_rd),
        .uart_d     (uart_d),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ack   (move_ack),
        .restart    (restart),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = one clock cycle of stimulus plus the outputs expected
    // right after the edge that samples it.
    typedef struct {
        logic       rd;
        logic [7:0] d;
        logic       ack;
        logic       v;
        logic [3:0] p;
        logic       e;
        logic       r;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic [7:0] d, input logic ack,
                       input logic v, input logic [3:0] p, input logic e,
                       input logic r);
        vec_t t;
        t.rd = rd; t.d = d; t.ack = ack; t.v = v; t.p = p; t.e = e; t.r = r;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic step(input logic rd, input logic [7:0] d, input logic ack);
        uart_rd  = rd;
        uart_d   = d;
        move_ack = ack;
        @(negedge clk);
        uart_rd  = 1'b0;
        uart_d   = 8'h00;
        move_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic idle_ack(input logic ack);
        step(1'b0, 8'h00, ack);
    endtask

    initial begin
        int first_err;
        int n_err;
        int n_mv;

        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        uart_rd  = 1'b0;
        uart_d   = 8'h00;
        move_ack = 1'b0;

        // Test 1: '5' CR, hold 10 cycles, ack
        add(1, 8'h35, 0, 0, 0, 0, 0);
        add(1, 8'h0D, 0, 1, 4, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 8'h00, 0, 1, 4, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);   // ack while not valid: ignored
        // Test 2: '9' CR LF, ack 3 cycles after valid, then 'R'
        add(1, 8'h39, 0, 0, 0, 0, 0);
        add(1, 8'h0D, 0, 1, 8, 0, 0);
        add(1, 8'h0A, 0, 1, 8, 0, 0);
        add(0, 8'h00, 0, 1, 8, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        add(1, 8'h52, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h20, 0, 0, 0, 0, 0);   // space in idle ignored
        add(1, 8'h72, 0, 0, 0, 0, 1);   // lowercase restart
        // Test 3: '0' CR, then '3' LF
        add(1, 8'h30, 0, 0, 0, 1, 0);
        add(1, 8'h0D, 0, 0, 0, 0, 0);
        add(1, 8'h33, 0, 0, 0, 0, 0);
        add(1, 8'h0A, 0, 1, 2, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        // Test 4: '2' '7' CR, then '1' CR (with a space after the digit)
        add(1, 8'h32, 0, 0, 0, 0, 0);
        add(1, 8'h37, 0, 0, 0, 1, 0);
        add(1, 8'h52, 0, 0, 0, 0, 0);   // 'R' in discard: silent, no restart
        add(1, 8'h0D, 0, 0, 0, 0, 0);
        add(1, 8'h31, 0, 0, 0, 0, 0);
        add(1, 8'h20, 0, 0, 0, 0, 0);
        add(1, 8'h0D, 0, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        // Test 6 first half: '8' CR, then 'x' while valid
        add(1, 8'h38, 0, 0, 0, 0, 0);
        add(1, 8'h0D, 0, 1, 7, 0, 0);
        add(1, 8'h78, 0, 1, 7, 1, 0);
        add(1, 8'h52, 0, 1, 7, 1, 0);   // 'R' while valid: err, never restart
        add(0, 8'h00, 0, 1, 7, 0, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", move_valid, 0);
        chk("reset_pos", move_pos, 0);
        chk("reset_err", err, 0);
        chk("reset_restart", restart, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rd, vecs[i].d, vecs[i].ack);
            chk($sformatf("vec%0d_valid", i), move_valid, vecs[i].v);
            if (vecs[i].v)
                chk($sformatf("vec%0d_pos", i), move_pos, vecs[i].p);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e);
            chk($sformatf("vec%0d_restart", i), restart, vecs[i].r);
        end

        // Async reset while the move is still pending
        reset = 1'b1;
        #1;
        chk("async_rst_valid", move_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        n_mv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (move_valid) n_mv++;
        end
        chk("post_rst_no_move", n_mv, 0);

        // Pending digit dropped by reset: a later CR yields nothing
        send(8'h32);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(8'h0D);
        chk("rst_drops_digit", move_valid, 0);

        // Timeout: '4' then idle; err 51 cycles after the strobe
        @(negedge clk);
        send(8'h34);                // strobe was cycle 0, now at cycle 1
        chk("to_err_early", err, 0);
        first_err = -1;
        n_err = 0;
        for (int i = 2; i <= 61; i++) begin
            @(negedge clk);
            if (err) begin
                n_err++;
                if (first_err < 0) first_err = i;
            end
        end
        chk("to_err_cycle", first_err, TO + 1);
        chk("to_err_count", n_err, 1);
        send(8'h36);
        chk("to_idle_no_err", err, 0);
        send(8'h0D);
        chk("to_next_valid", move_valid, 1);
        chk("to_next_pos", move_pos, 5);
        idle_ack(1'b1);
        chk("to_next_acked", move_valid, 0);

        // Terminator exactly in the expiry cycle wins
        send(8'h34);                // now at cycle 1
        n_err = 0;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (err) n_err++;
        end
        send(8'h0D);                // strobe in cycle 50
        if (err) n_err++;
        chk("edge_valid", move_valid, 1);
        chk("edge_pos", move_pos, 3);
        chk("edge_no_err", n_err, 0);
        idle_ack(1'b1);
        @(negedge clk);
        chk("edge_late_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
